line_fill_unit: RTL and testbench



---
 rtl/mem_pkg.sv | 17 +
 rtl/word_ram.sv | 26 ++
 rtl/line_fill_unit.sv | 143 ++++++++++++++
 tb/tb_line_fill_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-subsystem constants and the line-fill state encoding.
package mem_pkg;
    localparam int ADDR_W         = 12;
    localparam int DATA_W         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_W         = WORDS_PER_LINE * DATA_W;
    localparam int OFFSET_W       = 2;
    localparam int TAG_W          = ADDR_W - OFFSET_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_CAPTURE,
        ST_DONE
    } fill_state_e;
endpackage

// File: rtl/word_ram.sv
// Single-port word RAM, synchronous write and 1-cycle synchronous read, no reset.
module word_ram
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_fill_unit.sv
// Line-fill engine: reads the four words of a missed line from word_ram one beat
// at a time and returns the assembled line with its tag as a one-cycle response.
module line_fill_unit
    import mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [LINE_W-1:0] resp_line,
    output logic              busy
);

    localparam logic [3:0]  WAIT_LAST  = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    localparam fill_state_e BEAT_ENTRY = (WAIT_CYCLES > 0) ? ST_WAIT : ST_READ;

    fill_state_e               state_q, state_d;
    logic [TAG_W-1:0]          tag_q, tag_d;
    logic [OFFSET_W-1:0]       beat_q, beat_d;
    logic [3:0]                wait_q, wait_d;
    logic [3*DATA_W-1:0]       part_q, part_d;
    logic [LINE_W-1:0]         resp_line_q, resp_line_d;
    logic [TAG_W-1:0]          resp_tag_q, resp_tag_d;
    logic                      resp_valid_q, resp_valid_d;
    logic                      req_ready_q, req_ready_d;
    logic                      busy_q, busy_d;

    logic                      ram_we, ram_re;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_rdata;

    word_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        part_d      = part_q;
        resp_line_d = resp_line_q;
        resp_tag_d  = resp_tag_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = {tag_q, beat_q};

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_we) begin
                        ram_we   = 1'b1;
                        ram_addr = req_addr;
                    end else begin
                        tag_d   = req_addr[ADDR_W-1:OFFSET_W];
                        beat_d  = '0;
                        wait_d  = '0;
                        state_d = BEAT_ENTRY;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = ST_READ;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_READ: begin
                ram_re  = 1'b1;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Beats arrive in offset order, so shifting left leaves offset 0 on top.
                if (beat_q == 2'd3) begin
                    resp_line_d = {part_q, ram_rdata};
                    resp_tag_d  = tag_q;
                    state_d     = ST_DONE;
                end else begin
                    part_d  = {part_q[2*DATA_W-1:0], ram_rdata};
                    beat_d  = beat_q + 2'd1;
                    state_d = BEAT_ENTRY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        resp_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tag_q        <= '0;
            beat_q       <= '0;
            wait_q       <= '0;
            part_q       <= '0;
            resp_line_q  <= '0;
            resp_tag_q   <= '0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            beat_q       <= beat_d;
            wait_q       <= wait_d;
            part_q       <= part_d;
            resp_line_q  <= resp_line_d;
            resp_tag_q   <= resp_tag_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_tag   = resp_tag_q;
    assign resp_line  = resp_line_q;

endmodule

// File: tb/tb_line_fill_unit.sv
// Randomized bench for line_fill_unit: two instances (WAIT_CYCLES=2 and 0) checked
// against a word-array memory model and the documented fill latency.
`timescale 1ns/1ps
module tb_line_fill_unit;

    localparam int WC0 = 2;
    localparam int WC1 = 0;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid [2];
    logic         req_we    [2];
    logic         req_ready [2];
    logic         resp_valid[2];
    logic         busy      [2];
    logic [11:0]  req_addr  [2];
    logic [31:0]  req_wdata [2];
    logic [9:0]   resp_tag  [2];
    logic [127:0] resp_line [2];

    logic [31:0]  mem_m [4096];
    logic [9:0]   tags [$];
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    line_fill_unit #(.WAIT_CYCLES(WC0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_tag(resp_tag[0]), .resp_line(resp_line[0]),
        .busy(busy[0])
    );

    line_fill_unit #(.WAIT_CYCLES(WC1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_tag(resp_tag[1]), .resp_line(resp_line[1]),
        .busy(busy[1])
    );

    function automatic int lat(input int d);
        return 4 * (((d == 0) ? WC0 : WC1) + 2);
    endfunction

    function automatic logic [127:0] line_of(input logic [9:0] t);
        return {mem_m[{t, 2'd0}], mem_m[{t, 2'd1}], mem_m[{t, 2'd2}], mem_m[{t, 2'd3}]};
    endfunction

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = a; req_wdata[d] = v;
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0;
        end
        mem_m[a] = v;
    endtask

    task automatic fill(input int d, input logic [11:0] a);
        logic [127:0] exp;
        int cyc;
        exp = line_of(a[11:2]);
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = 1'b0; req_addr[d] = a;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        check("busy_in_fill", 128'(busy[d]), 128'(1));
        check("ready_low_in_fill", 128'(req_ready[d]), 128'(0));
        cyc = 0;
        while (!resp_valid[d] && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("fill_latency", 128'(cyc), 128'(lat(d)));
        check("fill_tag", 128'(resp_tag[d]), 128'(a[11:2]));
        check("fill_line", resp_line[d], exp);
        @(posedge clk); #1;
        check("resp_pulse_width", 128'(resp_valid[d]), 128'(0));
        check("ready_after_resp", 128'(req_ready[d]), 128'(1));
        check("resp_line_hold", resp_line[d], exp);
    endtask

    task automatic check_reset_vals(input string nm);
        for (int d = 0; d < 2; d++) begin
            check({nm, "_ready"}, 128'(req_ready[d]), 128'(1));
            check({nm, "_valid"}, 128'(resp_valid[d]), 128'(0));
            check({nm, "_busy"}, 128'(busy[d]), 128'(0));
            check({nm, "_tag"}, 128'(resp_tag[d]), 128'(0));
            check({nm, "_line"}, resp_line[d], 128'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] line_a, line_b;
        logic [9:0]   t;
        int           cyc, cnt, d;
        logic         rdy, acc;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        check_reset_vals("reset");

        // Directed line at words 0x010..0x013, filled via an unaligned address.
        wr(12'h010, 32'h11111111);
        wr(12'h011, 32'h22222222);
        wr(12'h012, 32'h33333333);
        wr(12'h013, 32'h44444444);
        tags.push_back(10'h004);
        fill(0, 12'h012);
        check("directed_line", resp_line[0], 128'h11111111_22222222_33333333_44444444);
        fill(1, 12'h012);
        check("directed_line_wc0", resp_line[1], 128'h11111111_22222222_33333333_44444444);

        // Write on the first acceptable edge after a response, then refill.
        wr(12'h013, 32'hDEADBEEF);
        fill(0, 12'h010);
        check("write_then_fill", 128'(resp_line[0][31:0]), 128'(32'hDEADBEEF));
        fill(1, 12'h011);
        check("write_then_fill_wc0", 128'(resp_line[1][31:0]), 128'(32'hDEADBEEF));

        // Preload the top line plus a set of random lines.
        tags.push_back(10'h3FF);
        for (int i = 0; i < 8; i++) tags.push_back(10'($urandom_range(0, 1022)));
        for (int i = 1; i < tags.size(); i++)
            for (int w = 0; w < 4; w++) wr({tags[i], 2'(w)}, $urandom);

        // Second request held during a fill is served only after req_ready returns.
        line_a = line_of(10'h004);
        line_b = line_of(10'h3FF);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 12'h011;
        @(posedge clk); #1;
        req_addr[0] = 12'hFFE;
        cyc = 0; acc = 1'b0;
        while (!acc && cyc < 200) begin
            rdy = req_ready[0];
            @(posedge clk); #1;
            cyc++;
            if (rdy) acc = 1'b1;
            if (resp_valid[0]) check("held_first_line", resp_line[0], line_a);
        end
        req_valid[0] = 1'b0;
        check("held_accept_spacing", 128'(cyc), 128'(lat(0) + 2));
        repeat (lat(0) - 1) @(posedge clk);
        #1;
        check("held_first_still_valid", 128'(resp_valid[0]), 128'(0));
        check("held_first_line_kept", resp_line[0], line_a);
        check("held_first_tag_kept", 128'(resp_tag[0]), 128'(10'h004));
        @(posedge clk); #1;
        check("held_second_valid", 128'(resp_valid[0]), 128'(1));
        check("held_second_tag", 128'(resp_tag[0]), 128'(10'h3FF));
        check("held_second_line", resp_line[0], line_b);
        @(posedge clk); #1;

        // Random mix of writes and fills against the model.
        for (int i = 0; i < 30; i++) begin
            t = tags[$urandom_range(0, tags.size() - 1)];
            if ($urandom_range(0, 2) == 0) begin
                wr({t, 2'($urandom_range(0, 3))}, $urandom);
            end else begin
                d = $urandom_range(0, 1);
                fill(d, {t, 2'($urandom_range(0, 3))});
            end
        end

        // Asynchronous reset five cycles into a fill.
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 12'h012;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk); rst = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (resp_valid[0]) cnt++;
        end
        check("no_resp_after_abort", 128'(cnt), 128'(0));
        fill(0, 12'hFFC);
        check("top_line_wc2", resp_line[0], line_of(10'h3FF));
        fill(1, 12'hFFF);
        check("top_line_wc0", resp_line[1], line_of(10'h3FF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
